multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multi-cycle instruction sequencer for the 32-bit CPU. Walks each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables: PC, IR, ALU, memory request and register-file write. It sits between the combinational opcode decoder and the datapath. It latches the decoder's regwrite/mem_load/mem_store/jump outputs and handshakes with a variable-latency memory.

## Interface
- RETIRE_W, 32, width of retired-instruction counter
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- run  input  1  enable; sampled only at instruction boundaries
- opcode  input  5  current IR opcode (valid from DECODE onward)
- regwrite  input  1  decoder: instruction writes register file
- mem_load  input  1  decoder: load
- mem_store  input  1  decoder: store
- jump  input  1  decoder: taken jump/branch (flag already resolved)
- mem_ready  input  1  memory completes request this cycle
- mem_req  output  1  memory request
- mem_we  output  1  write strobe (valid with mem_req)
- addr_sel  output  1  0 = PC address, 1 = ALU result address
- ir_write  output  1  load IR from memory data
- pc_write  output  1  update PC
- pc_src  output  1  0 = PC+1, 1 = jump target
- alu_en  output  1  ALU result register capture
- reg_we  output  1  register-file write
- wb_sel  output  1  0 = ALU result, 1 = memory data
- state  output  3  current state encoding
- busy  output  1  state not IDLE and not TRAP
- illegal  output  1  sticky illegal-opcode flag
- retired  output  RETIRE_W  count of completed instructions

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: all strobes 0. Goes to FETCH when run=1.
- FETCH: mem_req=1, addr_sel=0, mem_we=0, held until mem_ready=1. In that cycle ir_write=1, pc_write=1, pc_src=0, and next state is DECODE.
- DECODE: one cycle.
  - opcode 5'b11111 -> TRAP.
  - Otherwise latch regwrite/mem_load/mem_store/jump into internal flags, then go to EXEC.
- EXEC: alu_en=1 for one cycle. Next state by priority:
  - jump -> pc_write=1, pc_src=1, end of instruction.
  - mem_load or mem_store -> MEM.
  - regwrite -> WB.
  - else end of instruction.
- MEM: mem_req=1, addr_sel=1, mem_we=latched mem_store, held until mem_ready. On completion: load -> WB; store -> end of instruction.
- WB: reg_we=1, wb_sel=latched mem_load, one cycle, end of instruction.
- End of instruction: retired increments by 1, wrapping modulo 2^RETIRE_W. Next state is FETCH if run=1, else IDLE.
- TRAP: illegal=1, all strobes 0, retired frozen. Held until rst.
- mem_we, mem_load and mem_store both latched: load takes precedence, mem_we=0.

## Timing
- Reset (async): state=IDLE, every output 0, retired=0, illegal=0, latched flags 0.
- mem_req, mem_we, addr_sel, alu_en, reg_we, wb_sel are Moore outputs (state + latched flags).
- ir_write, pc_write and pc_src are Mealy outputs (state + mem_ready/jump).
- mem_ready is ignored when mem_req=0. If it is high in the first cycle of FETCH/MEM, the access completes that cycle (zero wait).
- Minimum latencies with zero-wait memory:
  - ALU op: 4 cycles.
  - Jump: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- run dropping mid-instruction does not abort it; the sequencer parks in IDLE after retirement.
- rst mid-MEM with mem_req high: mem_req drops immediately (asynchronously); no write strobe is issued after rst asserts.

## Structure
- Shared package `cpu_pkg`:
  - state encodings.
  - OPC_ILLEGAL=5'b11111.
  - opcode constants (ADD 00000, SUB 00010, LOAD 10110, STORE 10111, JMP 11000, BEQ 11001).
- Single module, no sub-modules. Next-state/output logic is combinational; the state, latched flags, illegal and retired counter are registered.

## Test plan
- Reset then run=1, mem_ready tied 1, ADD (regwrite=1) -> states 1,2,3,5,1; reg_we high exactly 1 cycle; wb_sel=0; retired=1 on cycle 4.
- LOAD with mem_ready delayed 2 cycles in MEM -> mem_req=1, addr_sel=1, mem_we=0 for 3 cycles; WB has wb_sel=1; total 7 cycles; retired increments once.
- STORE with zero-wait memory -> mem_we=1 for 1 cycle in MEM; no reg_we; back to FETCH after 4 cycles.
- JMP (jump=1) -> pc_write=1, pc_src=1 in EXEC; no MEM/WB visit; 3-cycle instruction.
- opcode 5'b11111 in DECODE -> state=6, illegal=1, all strobes 0 for 20 cycles regardless of run/mem_ready; rst clears to IDLE with illegal=0.
- run=0 asserted during EXEC of a load; rst pulsed during a later MEM wait -> load completes and parks in IDLE with retired+1; on rst, mem_req=0 and retired=0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 32-bit CPU: sequencer state encodings and opcodes.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [4:0] OPC_ILLEGAL = 5'b11111;
    localparam logic [4:0] OPC_ADD     = 5'b00000;
    localparam logic [4:0] OPC_SUB     = 5'b00010;
    localparam logic [4:0] OPC_LOAD    = 5'b10110;
    localparam logic [4:0] OPC_STORE   = 5'b10111;
    localparam logic [4:0] OPC_JMP     = 5'b11000;
    localparam logic [4:0] OPC_BEQ     = 5'b11001;

endpackage

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and handshakes with a
// variable-latency memory. An illegal opcode parks it in TRAP until reset.
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [4:0]          opcode,
    input  logic                regwrite,
    input  logic                mem_load,
    input  logic                mem_store,
    input  logic                jump,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_sel,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                alu_en,
    output logic                reg_we,
    output logic                wb_sel,
    output logic [2:0]          state,
    output logic                busy,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    state_t              r_state;
    state_t              w_nextState;
    logic                w_endInstr;
    logic                r_regwrite;
    logic                r_load;
    logic                r_store;
    logic                r_jump;
    logic                r_illegal;
    logic [RETIRE_W-1:0] r_retired;

    // State register; async reset returns to IDLE so memory strobes drop at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; every retiring path funnels through w_endInstr
    always_comb begin
        w_nextState = r_state;
        w_endInstr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) w_nextState = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready) w_nextState = ST_DECODE;
            end
            ST_DECODE: begin
                w_nextState = (opcode == OPC_ILLEGAL) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                if (r_jump)                 w_endInstr  = 1'b1;
                else if (r_load || r_store) w_nextState = ST_MEM;
                else if (r_regwrite)        w_nextState = ST_WB;
                else                        w_endInstr  = 1'b1;
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (r_load) w_nextState = ST_WB;
                    else        w_endInstr  = 1'b1;
                end
            end
            ST_WB: begin
                w_endInstr = 1'b1;
            end
            ST_TRAP: begin
                w_nextState = ST_TRAP;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
        if (w_endInstr) w_nextState = run ? ST_FETCH : ST_IDLE;
    end

    // Output decode: memory/ALU/writeback strobes follow state and latched
    // flags; IR/PC updates also depend on the memory handshake and jump flag
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src   = 1'b0;
        alu_en   = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            ST_EXEC: begin
                alu_en   = 1'b1;
                pc_write = r_jump;
                pc_src   = r_jump;
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = r_store & ~r_load;
            end
            ST_WB: begin
                reg_we = 1'b1;
                wb_sel = r_load;
            end
            default: begin
            end
        endcase
    end

    // Decoder flags are captured once in DECODE and steer EXEC/MEM/WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regwrite <= 1'b0;
            r_load     <= 1'b0;
            r_store    <= 1'b0;
            r_jump     <= 1'b0;
        end else if (r_state == ST_DECODE && opcode != OPC_ILLEGAL) begin
            r_regwrite <= regwrite;
            r_load     <= mem_load;
            r_store    <= mem_store;
            r_jump     <= jump;
        end
    end

    // Sticky illegal flag and wrapping retired-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            if (r_state == ST_DECODE && opcode == OPC_ILLEGAL) r_illegal <= 1'b1;
            if (w_endInstr) r_retired <= r_retired + 1'b1;
        end
    end

    assign state   = r_state;
    assign busy    = (r_state != ST_IDLE) && (r_state != ST_TRAP);
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer. Inputs change 1 time
// unit after the rising edge and outputs are sampled 1 unit later.
module tb_multicycle_sequencer;
    import cpu_pkg::*;

    // Strobe vector bit order: mem_req mem_we addr_sel ir_write pc_write
    // pc_src alu_en reg_we wb_sel
    typedef struct {
        logic       rdy;
        logic       rn;
        logic [2:0] st;
        logic [8:0] sb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [4:0]  opcode;
    logic        regwrite;
    logic        mem_load;
    logic        mem_store;
    logic        jump;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        alu_en;
    logic        reg_we;
    logic        wb_sel;
    logic [2:0]  state;
    logic        busy;
    logic        illegal;
    logic [31:0] retired;
    logic [8:0]  strobes;

    int nCompared   = 0;
    int nMismatched = 0;

    multicycle_sequencer #(.RETIRE_W(32)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .regwrite(regwrite), .mem_load(mem_load), .mem_store(mem_store),
        .jump(jump), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_en(alu_en),
        .reg_we(reg_we), .wb_sel(wb_sel), .state(state), .busy(busy),
        .illegal(illegal), .retired(retired)
    );

    assign strobes = {mem_req, mem_we, addr_sel, ir_write, pc_write,
                      pc_src, alu_en, reg_we, wb_sel};

    always #5 clk = ~clk;

    // Moves to just after the next rising edge
    task automatic advanceCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setInstr(input logic [4:0] opc, input logic rw,
                            input logic ld, input logic st, input logic jp);
        opcode    = opc;
        regwrite  = rw;
        mem_load  = ld;
        mem_store = st;
        jump      = jp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b0;
        mem_ready = 1'b1;
        setInstr(OPC_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        #12;
        nCompared++;
        if (state !== 3'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset state: got %0d expected 0", state);
        end
        nCompared++;
        if (strobes !== 9'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset strobes: got %b expected 000000000", strobes);
        end
        nCompared++;
        if ({busy, illegal} !== 2'b00 || retired !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset status: got busy=%b illegal=%b retired=%0d expected 0/0/0",
                     busy, illegal, retired);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu_op();
        vec_t tbl [5] = '{
            '{1'b1, 1'b1, 3'd1, 9'b100110000},
            '{1'b1, 1'b1, 3'd2, 9'b000000000},
            '{1'b1, 1'b1, 3'd3, 9'b000000100},
            '{1'b1, 1'b1, 3'd5, 9'b000000010},
            '{1'b1, 1'b1, 3'd1, 9'b100110000}
        };
        run = 1'b1;
        mem_ready = 1'b1;
        setInstr(OPC_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            advanceCycle();
            mem_ready = tbl[i].rdy;
            run = tbl[i].rn;
            #1;
            nCompared++;
            if (state !== tbl[i].st || strobes !== tbl[i].sb) begin
                nMismatched++;
                $display("[TB] FAIL alu cycle %0d: got state=%0d strobes=%b expected state=%0d strobes=%b",
                         i, state, strobes, tbl[i].st, tbl[i].sb);
            end
            nCompared++;
            if (busy !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL alu busy cycle %0d: got %b expected 1", i, busy);
            end
        end
        nCompared++;
        if (retired !== 32'd1) begin
            nMismatched++;
            $display("[TB] FAIL alu retired: got %0d expected 1", retired);
        end
    endtask

    task automatic test_load_wait();
        vec_t tbl [7] = '{
            '{1'b1, 1'b1, 3'd2, 9'b000000000},
            '{1'b0, 1'b1, 3'd3, 9'b000000100},
            '{1'b0, 1'b1, 3'd4, 9'b101000000},
            '{1'b0, 1'b1, 3'd4, 9'b101000000},
            '{1'b1, 1'b1, 3'd4, 9'b101000000},
            '{1'b1, 1'b1, 3'd5, 9'b000000011},
            '{1'b1, 1'b1, 3'd1, 9'b100110000}
        };
        setInstr(OPC_LOAD, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            advanceCycle();
            mem_ready = tbl[i].rdy;
            run = tbl[i].rn;
            #1;
            nCompared++;
            if (state !== tbl[i].st || strobes !== tbl[i].sb) begin
                nMismatched++;
                $display("[TB] FAIL load cycle %0d: got state=%0d strobes=%b expected state=%0d strobes=%b",
                         i, state, strobes, tbl[i].st, tbl[i].sb);
            end
            if (i == 5) begin
                nCompared++;
                if (retired !== 32'd1) begin
                    nMismatched++;
                    $display("[TB] FAIL load retired in WB: got %0d expected 1", retired);
                end
            end
        end
        nCompared++;
        if (retired !== 32'd2) begin
            nMismatched++;
            $display("[TB] FAIL load retired: got %0d expected 2", retired);
        end
    endtask

    task automatic test_store();
        vec_t tbl [4] = '{
            '{1'b1, 1'b1, 3'd2, 9'b000000000},
            '{1'b1, 1'b1, 3'd3, 9'b000000100},
            '{1'b1, 1'b1, 3'd4, 9'b111000000},
            '{1'b1, 1'b1, 3'd1, 9'b100110000}
        };
        setInstr(OPC_STORE, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            advanceCycle();
            mem_ready = tbl[i].rdy;
            run = tbl[i].rn;
            #1;
            nCompared++;
            if (state !== tbl[i].st || strobes !== tbl[i].sb) begin
                nMismatched++;
                $display("[TB] FAIL store cycle %0d: got state=%0d strobes=%b expected state=%0d strobes=%b",
                         i, state, strobes, tbl[i].st, tbl[i].sb);
            end
        end
        nCompared++;
        if (retired !== 32'd3) begin
            nMismatched++;
            $display("[TB] FAIL store retired: got %0d expected 3", retired);
        end
    endtask

    task automatic test_jump();
        vec_t tbl [3] = '{
            '{1'b1, 1'b1, 3'd2, 9'b000000000},
            '{1'b1, 1'b1, 3'd3, 9'b000011100},
            '{1'b1, 1'b1, 3'd1, 9'b100110000}
        };
        setInstr(OPC_JMP, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            advanceCycle();
            mem_ready = tbl[i].rdy;
            run = tbl[i].rn;
            #1;
            nCompared++;
            if (state !== tbl[i].st || strobes !== tbl[i].sb) begin
                nMismatched++;
                $display("[TB] FAIL jump cycle %0d: got state=%0d strobes=%b expected state=%0d strobes=%b",
                         i, state, strobes, tbl[i].st, tbl[i].sb);
            end
        end
        nCompared++;
        if (retired !== 32'd4) begin
            nMismatched++;
            $display("[TB] FAIL jump retired: got %0d expected 4", retired);
        end
    endtask

    task automatic test_run_drop_and_reset();
        vec_t tbl [11] = '{
            '{1'b1, 1'b1, 3'd2, 9'b000000000},
            '{1'b0, 1'b0, 3'd3, 9'b000000100},
            '{1'b1, 1'b0, 3'd4, 9'b101000000},
            '{1'b1, 1'b0, 3'd5, 9'b000000011},
            '{1'b1, 1'b0, 3'd0, 9'b000000000},
            '{1'b1, 1'b1, 3'd0, 9'b000000000},
            '{1'b1, 1'b1, 3'd1, 9'b100110000},
            '{1'b1, 1'b1, 3'd2, 9'b000000000},
            '{1'b0, 1'b1, 3'd3, 9'b000000100},
            '{1'b0, 1'b1, 3'd4, 9'b111000000},
            '{1'b0, 1'b1, 3'd4, 9'b111000000}
        };
        setInstr(OPC_LOAD, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            advanceCycle();
            if (i == 5) setInstr(OPC_STORE, 1'b0, 1'b0, 1'b1, 1'b0);
            mem_ready = tbl[i].rdy;
            run = tbl[i].rn;
            #1;
            nCompared++;
            if (state !== tbl[i].st || strobes !== tbl[i].sb) begin
                nMismatched++;
                $display("[TB] FAIL rundrop cycle %0d: got state=%0d strobes=%b expected state=%0d strobes=%b",
                         i, state, strobes, tbl[i].st, tbl[i].sb);
            end
            if (i == 4) begin
                nCompared++;
                if (retired !== 32'd5 || busy !== 1'b0) begin
                    nMismatched++;
                    $display("[TB] FAIL rundrop park: got retired=%0d busy=%b expected 5/0", retired, busy);
                end
            end
        end
        rst = 1'b1;
        #1;
        nCompared++;
        if (strobes !== 9'b0 || state !== 3'd0) begin
            nMismatched++;
            $display("[TB] FAIL mid-mem reset: got state=%0d strobes=%b expected 0/000000000",
                     state, strobes);
        end
        nCompared++;
        if (retired !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL mid-mem reset retired: got %0d expected 0", retired);
        end
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
    endtask

    task automatic test_trap();
        run = 1'b1;
        mem_ready = 1'b1;
        setInstr(OPC_ILLEGAL, 1'b0, 1'b0, 1'b0, 1'b0);
        advanceCycle();
        advanceCycle();
        nCompared++;
        if (state !== 3'd2 || illegal !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL trap decode: got state=%0d illegal=%b expected 2/0", state, illegal);
        end
        advanceCycle();
        nCompared++;
        if (state !== 3'd6 || illegal !== 1'b1 || busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL trap entry: got state=%0d illegal=%b busy=%b expected 6/1/0",
                     state, illegal, busy);
        end
        for (int i = 0; i < 20; i++) begin
            run = 1'($urandom_range(1));
            mem_ready = 1'($urandom_range(1));
            setInstr(5'($urandom_range(31)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                     1'($urandom_range(1)), 1'($urandom_range(1)));
            #1;
            nCompared++;
            if (state !== 3'd6 || strobes !== 9'b0 || illegal !== 1'b1 || retired !== 32'd0) begin
                nMismatched++;
                $display("[TB] FAIL trap hold %0d: got state=%0d strobes=%b illegal=%b retired=%0d expected 6/000000000/1/0",
                         i, state, strobes, illegal, retired);
            end
            advanceCycle();
        end
        rst = 1'b1;
        #1;
        nCompared++;
        if (state !== 3'd0 || illegal !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL trap reset: got state=%0d illegal=%b expected 0/0", state, illegal);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_wait();
        test_store();
        test_jump();
        test_run_drop_and_reset();
        test_trap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
